sqrt_seq_ctrl: RTL and testbench



---
 rtl/sqrt_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_sqrt_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_seq_ctrl.sv
// Control sequencer for the iterative square-root datapath.
// Handshaked start/done/ack, pipeline drain, iteration limit and counter.
module sqrt_seq_ctrl #(
   parameter int PIPE_DEPTH = 2,
   parameter int MAX_ITER   = 256,
   parameter int CNT_W      = $clog2(MAX_ITER + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             ack_i,
   input  logic             N_i,
   output logic             wr_input_o,
   output logic             wr_square_o,
   output logic             en_pipe_o,
   output logic             mux_root_o,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             overflow_o,
   output logic [CNT_W-1:0] iter_cnt_o
);

   localparam int DRN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
   localparam int DRN_V = (PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0;
   localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(DRN_V);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_ITER - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_ITER);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ITER  = 3'd2,
      DRAIN = 3'd3,
      SEL   = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] iter_cnt;
   logic             overflow;
   logic [DRN_W-1:0] drain_cnt;
   logic             at_limit;
   logic             iter_exit;

   assign at_limit  = (iter_cnt == CNT_LAST);
   assign iter_exit = N_i || at_limit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         iter_cnt  <= '0;
         overflow  <= 1'b0;
         drain_cnt <= '0;
      end else begin
         case (state)
            LOAD: begin
               iter_cnt <= '0;
               overflow <= 1'b0;
            end
            ITER: begin
               if (iter_cnt != CNT_MAX) begin
                  iter_cnt <= iter_cnt + 1'b1;
               end
               // N_i takes priority over the limit
               if (!N_i && at_limit) begin
                  overflow <= 1'b1;
               end
               if (iter_exit) begin
                  drain_cnt <= DRN_INIT;
               end
            end
            DRAIN: begin
               if (drain_cnt != '0) begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start_i) state_nx = LOAD;
         LOAD:  state_nx = ITER;
         ITER: begin
            if (iter_exit) begin
               state_nx = (PIPE_DEPTH == 0) ? SEL : DRAIN;
            end
         end
         DRAIN: if (drain_cnt == '0) state_nx = SEL;
         SEL:   state_nx = DONE;
         DONE:  if (ack_i) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      wr_input_o  = 1'b0;
      wr_square_o = 1'b0;
      en_pipe_o   = 1'b0;
      mux_root_o  = 1'b0;
      ready_o     = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      case (state)
         LOAD: begin
            wr_input_o = 1'b1;
            busy_o     = 1'b1;
         end
         ITER: begin
            wr_square_o = 1'b1;
            en_pipe_o   = 1'b1;
            ready_o     = 1'b1;
            busy_o      = 1'b1;
         end
         DRAIN: begin
            en_pipe_o = 1'b1;
            busy_o    = 1'b1;
         end
         SEL: begin
            en_pipe_o  = 1'b1;
            mux_root_o = 1'b1;
            busy_o     = 1'b1;
         end
         DONE: begin
            mux_root_o = 1'b1;
            done_o     = 1'b1;
         end
         default: ;
      endcase
   end

   assign overflow_o = overflow;
   assign iter_cnt_o = iter_cnt;

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Bench for sqrt_seq_ctrl: two instances (drain 2 and drain 0)
// checked cycle by cycle against an operation timeline model.
module tb_sqrt_seq_ctrl;

   localparam int M = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_i = 1'b0;
   logic ack_i = 1'b0;
   logic n_i = 1'b0;

   logic a_wi, a_ws, a_ep, a_mr, a_rd, a_bz, a_dn, a_ov;
   logic b_wi, b_ws, b_ep, b_mr, b_rd, b_bz, b_dn, b_ov;
   logic [3:0] a_cnt, b_cnt;

   int n_chk = 0;
   int n_pass = 0;
   int last_cnt = 0;
   bit last_ovf = 1'b0;

   always #5 clk = ~clk;

   sqrt_seq_ctrl #(.PIPE_DEPTH(2), .MAX_ITER(M)) u_a (
      .clk(clk), .rst(rst), .start_i(start_i), .ack_i(ack_i), .N_i(n_i),
      .wr_input_o(a_wi), .wr_square_o(a_ws), .en_pipe_o(a_ep),
      .mux_root_o(a_mr), .ready_o(a_rd), .busy_o(a_bz), .done_o(a_dn),
      .overflow_o(a_ov), .iter_cnt_o(a_cnt)
   );

   sqrt_seq_ctrl #(.PIPE_DEPTH(0), .MAX_ITER(M)) u_b (
      .clk(clk), .rst(rst), .start_i(start_i), .ack_i(ack_i), .N_i(n_i),
      .wr_input_o(b_wi), .wr_square_o(b_ws), .en_pipe_o(b_ep),
      .mux_root_o(b_mr), .ready_o(b_rd), .busy_o(b_bz), .done_o(b_dn),
      .overflow_o(b_ov), .iter_cnt_o(b_cnt)
   );

   // {wr_input, wr_square, en_pipe, mux_root, ready, busy, done}
   function automatic logic [6:0] act_vec(int d);
      if (d == 0) return {a_wi, a_ws, a_ep, a_mr, a_rd, a_bz, a_dn};
      return {b_wi, b_ws, b_ep, b_mr, b_rd, b_bz, b_dn};
   endfunction

   function automatic logic [4:0] act_st(int d);
      if (d == 0) return {a_cnt, a_ov};
      return {b_cnt, b_ov};
   endfunction

   // phase t cycles after the start edge: 1 LOAD, 2 ITER, 3 DRAIN, 4 SEL, 5 DONE
   function automatic int phase(int t, int k, int p);
      if (t == 1) return 1;
      if (t <= k + 1) return 2;
      if (t <= k + 1 + p) return 3;
      if (t == k + p + 2) return 4;
      return 5;
   endfunction

   function automatic logic [6:0] exp_vec(int ph);
      case (ph)
         1: return 7'b1000010;
         2: return 7'b0110110;
         3: return 7'b0010010;
         4: return 7'b0011010;
         5: return 7'b0001001;
         default: return 7'b0000000;
      endcase
   endfunction

   // n_at: ITER cycle (1-based) with N_i high, 0 = never
   task automatic run_op(input int n_at, input int hold, input int rst_at);
      int k, tdone, tack, ph, ec;
      int pd[2];
      bit ov, eo;
      logic [6:0] ev, av;
      logic [4:0] as;
      pd[0] = 2;
      pd[1] = 0;
      ov = !(n_at >= 1 && n_at <= M);
      k = ov ? M : n_at;
      tdone = k + 5;
      tack = tdone + hold;
      @(negedge clk);
      start_i = 1'b1;
      ack_i = 1'b0;
      n_i = 1'($urandom);
      for (int t = 1; t <= tack; t++) begin
         @(negedge clk);
         start_i = 1'b0;
         for (int d = 0; d < 2; d++) begin
            ph = phase(t, k, pd[d]);
            ev = exp_vec(ph);
            ec = (ph == 1) ? last_cnt : (ph == 2) ? t - 2 : k;
            eo = (ph == 1) ? last_ovf : (ph == 2) ? 1'b0 : ov;
            av = act_vec(d);
            as = act_st(d);
            n_chk++;
            if ({av, as} !== {ev, 4'(ec), eo}) begin
               $display("FAIL op d%0d t=%0d ph=%0d: got out=%b cnt=%0d ovf=%b, want out=%b cnt=%0d ovf=%b",
                        d, t, ph, av, as[4:1], as[0], ev, ec, eo);
            end else begin
               n_pass++;
            end
         end
         if (t == rst_at) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            last_cnt = 0;
            last_ovf = 1'b0;
            for (int c = 0; c < 4; c++) begin
               @(negedge clk);
               n_i = 1'($urandom);
               for (int d = 0; d < 2; d++) begin
                  n_chk++;
                  if ({act_vec(d), act_st(d)} !== 12'd0) begin
                     $display("FAIL rst_idle d%0d c=%0d: got %b, want 0",
                              d, c, {act_vec(d), act_st(d)});
                  end else begin
                     n_pass++;
                  end
               end
            end
            return;
         end
         if (t >= 2 && t <= k + 1) n_i = (t - 1 == n_at);
         else n_i = 1'($urandom);
         if (t >= tdone) start_i = 1'($urandom);
         if (t == tack) ack_i = 1'b1;
      end
      last_cnt = k;
      last_ovf = ov;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         start_i = 1'b0;
         ack_i = 1'b0;
         n_i = 1'($urandom);
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ({act_vec(d), act_st(d)} !== {7'd0, 4'(k), ov}) begin
               $display("FAIL idle_after d%0d c=%0d: got %b, want %b",
                        d, c, {act_vec(d), act_st(d)}, {7'd0, 4'(k), ov});
            end else begin
               n_pass++;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if ({act_vec(d), act_st(d)} !== 12'd0) begin
            $display("FAIL reset d%0d: got %b, want 0", d, {act_vec(d), act_st(d)});
         end else begin
            n_pass++;
         end
      end
      rst = 1'b0;
      last_cnt = 0;
      last_ovf = 1'b0;
   endtask

   task automatic test_n_early();
      run_op(4, 0, 0);
   endtask

   task automatic test_overflow();
      run_op(0, 1, 0);
   endtask

   task automatic test_n_at_limit();
      run_op(M, 0, 0);
   endtask

   task automatic test_first_cycle_exit();
      run_op(1, 2, 0);
   endtask

   task automatic test_done_hold();
      run_op(3, 5, 0);
      run_op(5, 0, 0);
   endtask

   task automatic test_reset_mid();
      run_op(5, 0, 3);
      run_op(2, 0, 4);
      run_op(6, 0, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) begin
         run_op($urandom_range(0, 10), $urandom_range(0, 3), 0);
      end
   endtask

   initial begin
      test_reset();
      test_n_early();
      test_overflow();
      test_n_at_limit();
      test_first_cycle_exit();
      test_done_hold();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
